// File: rtl/i2c_stretch_target.sv
// I2C target with masked address match, glitch-filtered inputs and SCL clock stretching.
// Bytes are exchanged with the clk-domain client over valid/ready streams.

module i2c_stretch_target_filt #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);
    logic       s1_q, s2_q, lvl_q;
    logic [3:0] cnt_q;

    // Level flips only after FILTER_LEN consecutive synchronised samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            lvl_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                lvl_q <= s2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign level_o = lvl_q;
endmodule

module i2c_stretch_target #(
    parameter logic [6:0] I2C_ADDRESS = 7'h42,
    parameter logic [6:0] ADDR_MASK   = 7'h7F,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_di,
    input  logic       sda_di,
    output logic       scl_pulldown,
    output logic       sda_pulldown,
    output logic [7:0] addr_rw,
    output logic       addr_stb,
    output logic       addr_match,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_nack_stb,
    output logic       start_stb,
    output logic       stop_stb,
    output logic       error_stb
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX_LOAD, S_TX, S_TX_ACK, S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       scl_f, sda_f, scl_prev_q, sda_prev_q;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d, addr_rw_q, addr_rw_d, rx_data_q, rx_data_d;
    logic       addr_match_q, addr_match_d, rx_valid_q, rx_valid_d;
    logic       sda_pd_q, sda_pd_d, scl_pd_q, scl_pd_d;
    logic       addr_stb_q, addr_stb_d, tx_ready_q, tx_ready_d, nack_q, nack_d;
    logic       start_q, start_d, stop_q, stop_d, err_q, err_d;
    logic       scl_rise, scl_fall, start_ev, stop_ev, match;
    logic [7:0] rx_byte;

    i2c_stretch_target_filt #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .raw_i(scl_di), .level_o(scl_f));
    i2c_stretch_target_filt #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .raw_i(sda_di), .level_o(sda_f));

    assign scl_rise = scl_f & ~scl_prev_q;
    assign scl_fall = ~scl_f & scl_prev_q;
    assign start_ev = ~sda_f & sda_prev_q & scl_f & scl_prev_q;
    assign stop_ev  = sda_f & ~sda_prev_q & scl_f & scl_prev_q;
    assign rx_byte  = {shift_q[6:0], sda_f};
    assign match    = ((rx_byte[7:1] ^ I2C_ADDRESS) & ADDR_MASK) == 7'd0;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        addr_rw_d    = addr_rw_q;
        addr_match_d = addr_match_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q & ~rx_ready;
        sda_pd_d     = sda_pd_q;
        scl_pd_d     = scl_pd_q;
        addr_stb_d   = 1'b0;
        tx_ready_d   = 1'b0;
        nack_d       = 1'b0;
        start_d      = 1'b0;
        stop_d       = 1'b0;
        err_d        = 1'b0;
        if (start_ev) begin
            start_d      = 1'b1;
            bitcnt_d     = '0;
            addr_match_d = 1'b0;
            sda_pd_d     = 1'b0;
            scl_pd_d     = 1'b0;
            state_d      = S_ADDR;
        end else if (stop_ev) begin
            stop_d   = 1'b1;
            // The STOP's own SCL rise has already been counted as a bit.
            err_d    = (state_q == S_RX || state_q == S_TX) && (bitcnt_q != 3'd1);
            sda_pd_d = 1'b0;
            scl_pd_d = 1'b0;
            state_d  = S_IDLE;
        end else begin
            unique case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d  = rx_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        addr_rw_d    = rx_byte;
                        addr_stb_d   = 1'b1;
                        addr_match_d = match;
                        state_d      = match ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!sda_pd_q) begin
                        sda_pd_d = 1'b1;
                    end else begin
                        sda_pd_d = 1'b0;
                        bitcnt_d = '0;
                        state_d  = addr_rw_q[0] ? S_TX_LOAD : S_RX;
                    end
                end
                S_RX: begin
                    if (scl_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bitcnt_q == 3'd0) begin
                        state_d = S_RX_ACK;
                    end
                end
                S_RX_ACK: begin
                    if (!sda_pd_q) begin
                        // Hold SCL low until the client has taken the byte, then ACK.
                        if (rx_valid_q && !rx_ready) begin
                            scl_pd_d = 1'b1;
                        end else begin
                            scl_pd_d = 1'b0;
                            sda_pd_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        sda_pd_d = 1'b0;
                        bitcnt_d = '0;
                        state_d  = S_RX;
                    end
                end
                S_TX_LOAD: begin
                    if (tx_valid) begin
                        shift_d    = tx_data;
                        tx_ready_d = 1'b1;
                        sda_pd_d   = ~tx_data[7];
                        scl_pd_d   = 1'b0;
                        bitcnt_d   = '0;
                        state_d    = S_TX;
                    end else begin
                        scl_pd_d = 1'b1;
                    end
                end
                S_TX: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bitcnt_q == 3'd0) begin
                            sda_pd_d = 1'b0;
                            state_d  = S_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_pd_d = ~shift_q[6];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise && sda_f) begin
                        nack_d  = 1'b1;
                        state_d = S_IGNORE;
                    end else if (scl_fall) begin
                        state_d = S_TX_LOAD;
                    end
                end
                default: begin
                    sda_pd_d = 1'b0;
                    scl_pd_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            addr_rw_q    <= '0;
            rx_data_q    <= '0;
            addr_match_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            sda_pd_q     <= 1'b0;
            scl_pd_q     <= 1'b0;
            addr_stb_q   <= 1'b0;
            tx_ready_q   <= 1'b0;
            nack_q       <= 1'b0;
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_prev_q   <= scl_f;
            sda_prev_q   <= sda_f;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            addr_rw_q    <= addr_rw_d;
            rx_data_q    <= rx_data_d;
            addr_match_q <= addr_match_d;
            rx_valid_q   <= rx_valid_d;
            sda_pd_q     <= sda_pd_d;
            scl_pd_q     <= scl_pd_d;
            addr_stb_q   <= addr_stb_d;
            tx_ready_q   <= tx_ready_d;
            nack_q       <= nack_d;
            start_q      <= start_d;
            stop_q       <= stop_d;
            err_q        <= err_d;
        end
    end

    assign scl_pulldown = scl_pd_q;
    assign sda_pulldown = sda_pd_q;
    assign addr_rw      = addr_rw_q;
    assign addr_stb     = addr_stb_q;
    assign addr_match   = addr_match_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_ready     = tx_ready_q;
    assign tx_nack_stb  = nack_q;
    assign start_stb    = start_q;
    assign stop_stb     = stop_q;
    assign error_stb    = err_q;
endmodule

// File: tb/tb_i2c_stretch_target.sv
// Bit-banged I2C master against i2c_stretch_target; address and RX bytes are checked
// through scoreboard queues, bus events through strobe counters.
module tb_i2c_stretch_target;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic scl_m = 1'b1, sda_m = 1'b1, sel = 1'b0;
    logic scl_line, sda_line;

    logic       scl_pd1, sda_pd1, addr_stb1, addr_match1, rx_valid1, tx_ready1, nack1;
    logic       start1, stop1, err1;
    logic [7:0] addr_rw1, rx_data1;
    logic       rx_ready1 = 1'b1, tx_valid1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00;

    logic       scl_pd2, sda_pd2, addr_stb2, addr_match2, rx_valid2, tx_ready2, nack2;
    logic       start2, stop2, err2;
    logic [7:0] addr_rw2, rx_data2;

    // Open-drain bus: only the selected target is wired to the master.
    assign scl_line = scl_m & ~(sel ? scl_pd2 : scl_pd1);
    assign sda_line = sda_m & ~(sel ? sda_pd2 : sda_pd1);

    i2c_stretch_target dut (
        .clk(clk), .rst(rst), .scl_di(sel ? 1'b1 : scl_line), .sda_di(sel ? 1'b1 : sda_line),
        .scl_pulldown(scl_pd1), .sda_pulldown(sda_pd1), .addr_rw(addr_rw1), .addr_stb(addr_stb1),
        .addr_match(addr_match1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_nack_stb(nack1),
        .start_stb(start1), .stop_stb(stop1), .error_stb(err1));

    i2c_stretch_target #(.ADDR_MASK(7'h7E)) dut_m (
        .clk(clk), .rst(rst), .scl_di(sel ? scl_line : 1'b1), .sda_di(sel ? sda_line : 1'b1),
        .scl_pulldown(scl_pd2), .sda_pulldown(sda_pd2), .addr_rw(addr_rw2), .addr_stb(addr_stb2),
        .addr_match(addr_match2), .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(1'b1),
        .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(tx_ready2), .tx_nack_stb(nack2),
        .start_stb(start2), .stop_stb(stop2), .error_stb(err2));

    int n_chk = 0, n_fail = 0;
    int n_start = 0, n_stop = 0, n_err = 0, n_txr = 0, n_nack = 0, n_sclpd = 0;
    logic [8:0] exp_addr[$];   // {match, addr_rw}
    logic [7:0] exp_rx[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_start += int'(start1);
            n_stop  += int'(stop1);
            n_err   += int'(err1);
            n_txr   += int'(tx_ready1);
            n_nack  += int'(nack1);
            n_sclpd += int'(scl_pd1);
            if (addr_stb1) begin
                chk("addr_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) begin
                    logic [8:0] e;
                    e = exp_addr.pop_front();
                    chk("addr_rw", addr_rw1, e[7:0]);
                    chk("addr_match", addr_match1, e[8]);
                end
            end
            if (rx_valid1 && rx_ready1) begin
                chk("rx_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) chk("rx_data", rx_data1, exp_rx.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_scl_high();
        int t = 0;
        while (!scl_line && t < 4000) begin tick(1); t++; end
        chk("scl_high", scl_line, 1);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        tick(10); sda_m = b;
        tick(10); scl_m = 1'b1;
        wait_scl_high();
        tick(10); r = sda_line;
        tick(10); scl_m = 1'b0;
    endtask

    task automatic start_c();
        if (!scl_m) begin
            tick(10); sda_m = 1'b1;
            tick(10); scl_m = 1'b1;
            wait_scl_high();
            tick(10);
        end
        sda_m = 1'b0;
        tick(20); scl_m = 1'b0;
    endtask

    task automatic stop_c();
        tick(10); sda_m = 1'b0;
        tick(10); scl_m = 1'b1;
        wait_scl_high();
        tick(20); sda_m = 1'b1;
        tick(30);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, r); d[i] = r; end
        clk_bit(~ack, r);
    endtask

    task automatic wait_rxv();
        int t = 0;
        while (!rx_valid1 && t < 20000) begin tick(1); t++; end
        chk("rx_valid_seen", rx_valid1, 1);
    endtask

    task automatic wait_txr();
        int t = 0;
        while (!tx_ready1 && t < 20000) begin tick(1); t++; end
        chk("tx_ready_seen", tx_ready1, 1);
    endtask

    task automatic wait_sclpd();
        int t = 0;
        while (!scl_pd1 && t < 20000) begin tick(1); t++; end
        chk("stretch_seen", scl_pd1, 1);
    endtask

    logic       ack, r;
    logic [7:0] d;
    int c_start, c_stop, c_err, c_txr, c_nack, c_sclpd;

    task automatic snap();
        c_start = n_start; c_stop = n_stop; c_err = n_err;
        c_txr = n_txr; c_nack = n_nack; c_sclpd = n_sclpd;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(4);
        chk("rst_pulldowns", {scl_pd1, sda_pd1}, 2'b00);
        chk("rst_outs", {addr_rw1, addr_stb1, addr_match1, rx_data1, rx_valid1, tx_ready1,
                         nack1, start1, stop1, err1}, 0);
        rst = 1'b0;
        tick(10);

        // Plain write, client always ready: no stretching at all.
        snap();
        start_c();
        exp_addr.push_back({1'b1, 8'h84}); write_byte(8'h84, ack); chk("w_addr_ack", ack, 1);
        exp_rx.push_back(8'h5A); write_byte(8'h5A, ack); chk("w_b1_ack", ack, 1);
        exp_rx.push_back(8'hC3); write_byte(8'hC3, ack); chk("w_b2_ack", ack, 1);
        stop_c();
        chk("w_start", n_start - c_start, 1);
        chk("w_stop", n_stop - c_stop, 1);
        chk("w_no_stretch", n_sclpd - c_sclpd, 0);

        // Client stalls 50 cycles after the first data byte.
        rx_ready1 = 1'b0;
        fork
            begin
                start_c();
                exp_addr.push_back({1'b1, 8'h84}); write_byte(8'h84, ack); chk("s_addr_ack", ack, 1);
                exp_rx.push_back(8'h5A); write_byte(8'h5A, ack); chk("s_b1_ack", ack, 1);
                exp_rx.push_back(8'hC3); write_byte(8'hC3, ack); chk("s_b2_ack", ack, 1);
                stop_c();
            end
            begin
                wait_rxv();
                tick(50);
                chk("s_stretching", scl_pd1, 1);
                rx_ready1 = 1'b1;
                tick(2);
                chk("s_released", scl_pd1, 0);
            end
        join

        // Read with late tx_valid, master NACKs.
        snap();
        tx_data1 = 8'hA5;
        start_c();
        exp_addr.push_back({1'b1, 8'h85}); write_byte(8'h85, ack); chk("r_addr_ack", ack, 1);
        fork
            read_byte(1'b0, d);
            begin tick(30); tx_valid1 = 1'b1; wait_txr(); tx_valid1 = 1'b0; end
        join
        chk("r_data", d, 8'hA5);
        chk("r_stretched", n_sclpd - c_sclpd != 0, 1);
        tick(2);
        chk("r_tx_ready", n_txr - c_txr, 1);
        chk("r_nack", n_nack - c_nack, 1);
        chk("r_sda_free", sda_pd1, 0);
        stop_c();

        // Address 0x43: ignored by the exact-match target, accepted by the masked one.
        snap();
        start_c();
        exp_addr.push_back({1'b0, 8'h86}); write_byte(8'h86, ack); chk("x_no_ack", ack, 0);
        stop_c();
        chk("x_no_stretch", n_sclpd - c_sclpd, 0);
        sel = 1'b1;
        start_c();
        write_byte(8'h86, ack);
        chk("m_ack", ack, 1);
        chk("m_addr_rw", addr_rw2, 8'h86);
        chk("m_match", addr_match2, 1);
        stop_c();
        sel = 1'b0;
        tick(10);

        // STOP after 4 data bits, then a short SDA glitch while idle.
        snap();
        start_c();
        exp_addr.push_back({1'b1, 8'h84}); write_byte(8'h84, ack); chk("e_addr_ack", ack, 1);
        clk_bit(1'b1, r); clk_bit(1'b0, r); clk_bit(1'b1, r); clk_bit(1'b1, r);
        stop_c();
        chk("e_error", n_err - c_err, 1);
        chk("e_stop", n_stop - c_stop, 1);
        chk("e_no_rx", rx_valid1, 0);
        snap();
        @(negedge clk); sda_m = 1'b0;
        repeat (2) @(negedge clk); sda_m = 1'b1;
        tick(20);
        chk("g_no_start", n_start - c_start, 0);
        chk("g_no_stop", n_stop - c_stop, 0);

        // Repeated START during a read turns the transaction into a write.
        snap();
        tx_data1 = 8'hFF; tx_valid1 = 1'b1;
        start_c();
        exp_addr.push_back({1'b1, 8'h85}); write_byte(8'h85, ack); chk("rs_addr_ack", ack, 1);
        tick(10); tx_valid1 = 1'b0;
        start_c();
        exp_addr.push_back({1'b1, 8'h84}); write_byte(8'h84, ack); chk("rs_w_ack", ack, 1);
        exp_rx.push_back(8'h3C); write_byte(8'h3C, ack); chk("rs_b_ack", ack, 1);
        stop_c();
        chk("rs_starts", n_start - c_start, 2);
        chk("rs_tx_ready", n_txr - c_txr, 1);

        // Reset while stretching releases SCL on the next cycle.
        rx_ready1 = 1'b0;
        fork
            begin
                start_c();
                exp_addr.push_back({1'b1, 8'h84}); write_byte(8'h84, ack);
                write_byte(8'h77, ack);
                stop_c();
            end
            begin
                wait_sclpd();
                tick(5);
                rst = 1'b1;
                tick(1);
                chk("rst_scl_free", scl_pd1, 0);
                chk("rst_sda_free", sda_pd1, 0);
                rst = 1'b0;
            end
        join
        rx_ready1 = 1'b1;
        tick(20);
        chk("end_rx_q", exp_rx.size(), 0);
        chk("end_addr_q", exp_addr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_stretch_target.md
Name: i2c_stretch_target

Overview:
- Parametrised I2C target (slave) that succeeds the fixed-address simple slave.
- Adds a masked/multi-address match, an input glitch filter, and true SCL clock stretching.
- Uses valid/ready byte streams for RX and TX, handles repeated START and STOP in any state, and reports master NACK.
- Sits between the open-drain pad logic (di/pulldown pairs) and a register-file or FIFO client in the `clk` domain.

Parameters:
- `I2C_ADDRESS`, 7'h42: target address.
- `ADDR_MASK`, 7'h7F: address bits compared; a bit at 0 is don't-care.
- `FILTER_LEN`, 3: consecutive equal synchronised samples required before a filtered SCL/SDA level changes (1..15).

Ports:
- `clk` input 1: system clock.
- `rst` input 1: reset. Synchronous, active-high.
- `scl_di` input 1: raw SCL pad input.
- `sda_di` input 1: raw SDA pad input.
- `scl_pulldown` output 1: 1 = drive SCL low (stretch).
- `sda_pulldown` output 1: 1 = drive SDA low.
- `addr_rw` output 8: last received address byte {addr[6:0], r/w}.
- `addr_stb` output 1: 1-cycle pulse when `addr_rw` is updated.
- `addr_match` output 1: level, valid from `addr_stb` until the next START.
- `rx_data` output 8: byte written by the master.
- `rx_valid` output 1: `rx_data` held; cleared by the handshake.
- `rx_ready` input 1: client accepts `rx_data`.
- `tx_data` input 8: byte to send to the master.
- `tx_valid` input 1: `tx_data` available.
- `tx_ready` output 1: 1-cycle pulse when `tx_data` is loaded.
- `tx_nack_stb` output 1: pulse when the master NACKs a read byte.
- `start_stb` output 1: pulse on START or repeated START.
- `stop_stb` output 1: pulse on STOP.
- `error_stb` output 1: pulse on STOP mid-byte.

Behaviour:
- **Reset**
  - `rst` sampled on `clk` rising edge.
  - All outputs are 0, state is IDLE, filters are loaded to 1.
  - Reset mid-transfer releases both pulldowns on the next cycle; the bus is ignored until the next START.
- **Input path and edge detection**
  - Each input passes a 2-flop synchroniser, then the filter. Input-to-filtered latency is 2+`FILTER_LEN` cycles.
  - Edges are computed from the filtered level and its previous value.
  - Integration requirement: (`FILTER_LEN`+4) × Tclk < tLOW.
- **Bus events** (highest priority, in any state):
  - START is a filtered SDA fall while SCL = 1. Action: `start_stb`, clear bit count, go to ADDR.
  - STOP is a filtered SDA rise while SCL = 1. Action: `stop_stb`, release pulldowns, go to IDLE.
  - STOP in RX or TX with bit count 1..7 also pulses `error_stb`.
- **Bit timing**
  - Bits are sampled MSB first on the SCL rising edge.
  - Target-driven SDA changes only on the SCL falling edge.
- **States**
  - **IDLE**: wait for START.
  - **ADDR**:
    - Shift 8 bits.
    - After the 8th: load `addr_rw`, pulse `addr_stb`, and set `addr_match` = ((`addr` ^ `I2C_ADDRESS`) & `ADDR_MASK`) == 0.
    - On a match go to ADDR_ACK; otherwise go to IGNORE.
  - **ADDR_ACK**:
    - On the SCL fall, set `sda_pulldown` = 1.
    - On the next SCL fall, release SDA.
    - If r/w = 0 go to RX; if r/w = 1 go to TX_LOAD.
  - **RX**:
    - Shift 8 bits; the 8th rise sets `rx_data` and `rx_valid` = 1.
    - On the next SCL fall go to RX_ACK.
  - **RX_ACK**:
    - If `rx_valid` is still 1: `scl_pulldown` = 1 (stretch) until the cycle `rx_valid` & `rx_ready`.
    - Then release SCL and drive the ACK.
    - Release SDA on the next SCL fall, then go to RX.
  - **TX_LOAD**:
    - Entered with SCL low.
    - If `tx_valid` is 1: load the shift register, pulse `tx_ready`, drive bit 7, go to TX.
    - Otherwise `scl_pulldown` = 1 until `tx_valid`. The load and SCL release happen in the same cycle, so SDA is set up before SCL can rise.
  - **TX**:
    - On each SCL fall, shift and drive the next bit (`sda_pulldown` = ~bit).
    - After the 8th bit's SCL fall, release SDA and go to TX_ACK.
  - **TX_ACK**:
    - Sample SDA on the SCL rise.
    - If 0 (ACK): on the SCL fall go to TX_LOAD.
    - If 1 (NACK): pulse `tx_nack_stb` and go to IGNORE.
  - **IGNORE**: pulldowns are 0; wait for START or STOP.
- **Handshakes**
  - `rx_valid` stays 1 until `rx_ready` is seen. `rx_data` is stable while `rx_valid` = 1.
  - `tx_ready` is asserted only in TX_LOAD.
- **Simultaneous events**
  - A bus event outranks a bit edge in the same cycle.
  - A START while stretching releases SCL immediately.
  - The `rx_valid` & `rx_ready` handshake completes even if a STOP arrives in the same cycle.
- **Counters**: 3-bit bit count; wrap 7→0 ends the byte.

Test Plan:
- Write 0x84 (addr 0x42, W), then 0x5A, 0xC3, STOP, with `rx_ready` = 1 → ACK driven after each byte; `rx_data` = 0x5A then 0xC3; one `stop_stb`; `scl_pulldown` never 1.
- Same write with `rx_ready` held 0 for 50 cycles after the first byte → `scl_pulldown` = 1 from the ACK SCL fall until the `rx_ready` cycle; byte 2 is still received correctly.
- Read 0x85 with `tx_valid` raised 30 cycles after the ACK, `tx_data` = 0xA5, master NACK → stretch until `tx_valid`; SDA bits 1,0,1,0,0,1,0,1; `tx_ready` pulses once; `tx_nack_stb` = 1; SDA released.
- Address 0x43 with default mask → `addr_stb`, `addr_match` = 0, no ACK, no stretch. With `ADDR_MASK` = 7'h7E, address 0x43 gives `addr_match` = 1 and an ACK.
- STOP after 4 data bits → `error_stb` and `stop_stb` pulse; state IDLE. An SDA glitch of `FILTER_LEN`-1 cycles while SCL is high → no START/STOP.
- Repeated START mid-read, then 0x84 write → `start_stb` twice; transaction continues as a write. Asserting `rst` mid-stretch → `scl_pulldown` = 0 on the next cycle.
